rx_uart: RTL

Serial receiver that consumes the 8N1 line produced by `tx_uart` and turns it back into bytes. It sits between the external RX pin and the memory-mapped I/O path: the CPU-side logic polls `data_valid` and pops each byte with `read_enable`. Bit period comes from the same runtime `cycles` value used by `tx_uart`, so both directions share one baud setting. Frame format is 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.

---
 rtl/rx_uart.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rx_uart.sv
// rx_uart: 8N1 serial receiver (1 start, 8 data LSB first, 1 stop, no parity).
// The bit period is a runtime value shared with tx_uart and is latched at frame start.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   cycles[27:0]  clock cycles per bit (>= 4), latched on start-bit detection
//   rx_line       asynchronous serial input, idle high
//   read_enable   consumer pop; clears data_valid, framing_error, overrun
//   read_data     last correctly received byte
//   data_valid    an unread byte is held in read_data
//   framing_error sticky: a stop bit was sampled low
//   overrun       sticky: a byte completed while data_valid was already high
module rx_uart (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [27:0] cycles,
  input  logic        rx_line,
  input  logic        read_enable,
  output logic [7:0]  read_data,
  output logic        data_valid,
  output logic        framing_error,
  output logic        overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t      state, state_n;
  logic        sync1, rx_s;
  logic [27:0] cnt, cnt_n;
  logic [27:0] cyc_l, cyc_l_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  read_data_n;
  logic        dv_n, fe_n, ov_n;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_line;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      cyc_l         <= '0;
      idx           <= '0;
      shreg         <= '0;
      read_data     <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      cyc_l         <= cyc_l_n;
      idx           <= idx_n;
      shreg         <= shreg_n;
      read_data     <= read_data_n;
      data_valid    <= dv_n;
      framing_error <= fe_n;
      overrun       <= ov_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = (cnt == '0) ? cnt : cnt - 28'd1;
    cyc_l_n     = cyc_l;
    idx_n       = idx;
    shreg_n     = shreg;
    read_data_n = read_data;
    // Pop clears first; any set event below overrides it on the same edge.
    dv_n        = data_valid    & ~read_enable;
    fe_n        = framing_error & ~read_enable;
    ov_n        = overrun       & ~read_enable;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          cyc_l_n = cycles;
          cnt_n   = (cycles >> 1) - 28'd1;
          state_n = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (!rx_s) begin
            cnt_n   = cyc_l - 28'd1;
            idx_n   = '0;
            state_n = DATA;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shreg_n[idx] = rx_s;
          cnt_n        = cyc_l - 28'd1;
          if (idx == 3'd7) begin
            state_n = STOP;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            if (data_valid && !read_enable) begin
              ov_n = 1'b1;
            end else begin
              read_data_n = shreg;
              dv_n        = 1'b1;
            end
            state_n = IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
